// File: rtl/counter.sv
// counter: loadable down-counter with a registered terminal-count flag.
//
// Load restarts a count of CNT_INIT edges; K rises on the edge that takes the
// count from 1 to 0 and stays high until the next Load or Reset. Reset is
// asynchronous and active high.
//
// Optional build macro COUNTER_STATUS_EN adds the Count and Busy status
// ports. K timing does not depend on the macro.
module counter #(
  parameter int CNT_W    = 4,
  parameter int CNT_INIT = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
`ifdef COUNTER_STATUS_EN
  output logic [CNT_W-1:0] Count,
  output logic             Busy,
`endif
  output logic             K
);

  // Reject a load value that is zero or does not fit in the counter.
  if (CNT_INIT < 1 || CNT_INIT > (2**CNT_W) - 1) begin : g_bad_init
    $error("counter: CNT_INIT out of range for CNT_W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(CNT_INIT);
  localparam logic [CNT_W-1:0] ONE_VAL  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             k_q, k_d;

  // State, count and K registers; Reset clears them without a clock edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= '0;
      k_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      k_q     <= k_d;
    end
  end

  // Next state: Load wins in every state; RUN counts down and flags DONE
  // on the 1 -> 0 step; IDLE and DONE simply hold.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    k_d     = k_q;
    if (Load) begin
      state_d = RUN;
      count_d = INIT_VAL;
      k_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          count_d = '0;
          k_d     = 1'b0;
        end
        RUN: begin
          // A zero count in RUN is unreachable; treat it like the last step
          // so the machine can never wrap.
          if (count_q == ONE_VAL || count_q == '0) begin
            state_d = DONE;
            count_d = '0;
            k_d     = 1'b1;
          end else begin
            count_d = count_q - ONE_VAL;
            k_d     = 1'b0;
          end
        end
        DONE: begin
          count_d = '0;
          k_d     = 1'b1;
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
          k_d     = 1'b0;
        end
      endcase
    end
  end

  // K comes straight from its flop, so Load never reaches it combinationally.
  assign K = k_q;

`ifdef COUNTER_STATUS_EN
  assign Count = count_q;
  assign Busy  = (state_q == RUN);
`endif

endmodule

// File: tb/tb_counter.sv
// tb_counter: randomized and directed checks of counter against a model that
// tracks only "has a load happened" and "edges since the last load".
module tb_counter;

  localparam int CNT_W    = 4;
  localparam int CNT_INIT = 8;

  logic             Clk;
  logic             Reset;
  logic             Load;
  logic             K;
`ifdef COUNTER_STATUS_EN
  logic [CNT_W-1:0] Count;
  logic             Busy;
`endif

  int checks;
  int errors;

  // Reference model state.
  bit loaded;
  int since;

  counter #(.CNT_W(CNT_W), .CNT_INIT(CNT_INIT)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Load  (Load),
`ifdef COUNTER_STATUS_EN
    .Count (Count),
    .Busy  (Busy),
`endif
    .K     (K)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic exp_k();
    return loaded && (since >= CNT_INIT);
  endfunction

  function automatic int exp_cnt();
    if (!loaded) return 0;
    return (since >= CNT_INIT) ? 0 : CNT_INIT - since;
  endfunction

  function automatic logic exp_busy();
    return loaded && (since < CNT_INIT);
  endfunction

  // Drive Load, take one edge, sample 1ns later and advance the model.
  task automatic step(input logic l);
    Load = l;
    @(posedge Clk);
    #1;
    if (Reset) begin
      loaded = 0;
      since  = 0;
    end else if (l) begin
      loaded = 1;
      since  = 0;
    end else if (loaded) begin
      since++;
    end
  endtask

  task automatic model_reset();
    loaded = 0;
    since  = 0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Load  = 1'b0;
    #2;
    checks++;
    if (K !== 1'b0) begin
      errors++;
      $display("FAIL reset_k got %b want 0", K);
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      checks++;
      if (K !== 1'b0) begin
        errors++;
        $display("FAIL idle_k edge %0d got %b want 0", i, K);
      end
`ifdef COUNTER_STATUS_EN
      checks++;
      if (Count !== CNT_W'(0) || Busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_status edge %0d count %0d busy %b want 0 0", i, Count, Busy);
      end
`endif
    end
  endtask

  task automatic test_countdown();
    step(1'b1);
    for (int i = 0; i <= CNT_INIT; i++) begin
      checks++;
      if (K !== exp_k()) begin
        errors++;
        $display("FAIL countdown_k step %0d got %b want %b", i, K, exp_k());
      end
`ifdef COUNTER_STATUS_EN
      checks++;
      if (Count !== CNT_W'(exp_cnt()) || Busy !== exp_busy()) begin
        errors++;
        $display("FAIL countdown_status step %0d count %0d busy %b want %0d %b",
                 i, Count, Busy, exp_cnt(), exp_busy());
      end
`endif
      if (i < CNT_INIT) step(1'b0);
    end
    checks++;
    if (K !== 1'b1) begin
      errors++;
      $display("FAIL countdown_final_k got %b want 1", K);
    end
  endtask

  task automatic test_done_hold();
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      checks++;
      if (K !== 1'b1) begin
        errors++;
        $display("FAIL done_hold_k edge %0d got %b want 1", i, K);
      end
`ifdef COUNTER_STATUS_EN
      checks++;
      if (Count !== CNT_W'(0)) begin
        errors++;
        $display("FAIL done_hold_count edge %0d got %0d want 0", i, Count);
      end
`endif
    end
  endtask

  task automatic test_reload_done();
    step(1'b1);
    checks++;
    if (K !== 1'b0) begin
      errors++;
      $display("FAIL reload_done_k got %b want 0", K);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      checks++;
      if (K !== exp_k()) begin
        errors++;
        $display("FAIL reload_done_run_k edge %0d got %b want %b", i, K, exp_k());
      end
`ifdef COUNTER_STATUS_EN
      checks++;
      if (Count !== CNT_W'(exp_cnt())) begin
        errors++;
        $display("FAIL reload_done_count edge %0d got %0d want %0d", i, Count, exp_cnt());
      end
`endif
    end
  endtask

  task automatic test_restart_run();
    int first_k;
    step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);
    step(1'b1);
    first_k = -1;
    for (int i = 1; i <= CNT_INIT + 2; i++) begin
      step(1'b0);
      if (K === 1'b1 && first_k < 0) first_k = i;
    end
    checks++;
    if (first_k != CNT_INIT) begin
      errors++;
      $display("FAIL restart_run_k_edge got %0d want %0d", first_k, CNT_INIT);
    end
  endtask

  task automatic test_load_held();
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      checks++;
      if (K !== 1'b0) begin
        errors++;
        $display("FAIL load_held_k edge %0d got %b want 0", i, K);
      end
`ifdef COUNTER_STATUS_EN
      checks++;
      if (Count !== CNT_W'(CNT_INIT)) begin
        errors++;
        $display("FAIL load_held_count edge %0d got %0d want %0d", i, Count, CNT_INIT);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    // Mid-count abort.
    step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (K !== 1'b0) begin
      errors++;
      $display("FAIL async_mid_k got %b want 0", K);
    end
`ifdef COUNTER_STATUS_EN
    checks++;
    if (Count !== CNT_W'(0) || Busy !== 1'b0) begin
      errors++;
      $display("FAIL async_mid_status count %0d busy %b want 0 0", Count, Busy);
    end
`endif
    // Load is ignored while Reset is held.
    for (int i = 0; i < 3; i++) step(1'b1);
    Reset = 1'b0;
    for (int i = 0; i < CNT_INIT + 3; i++) begin
      step(1'b0);
      checks++;
      if (K !== 1'b0) begin
        errors++;
        $display("FAIL async_no_pulse_k edge %0d got %b want 0", i, K);
      end
    end
    // Reset from DONE drops K before any edge.
    step(1'b1);
    for (int i = 0; i < CNT_INIT; i++) step(1'b0);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (K !== 1'b0) begin
      errors++;
      $display("FAIL async_done_k got %b want 0", K);
    end
    Reset = 1'b0;
    // Fresh count after reset.
    step(1'b1);
    for (int i = 0; i < CNT_INIT; i++) step(1'b0);
    checks++;
    if (K !== 1'b1) begin
      errors++;
      $display("FAIL async_fresh_k got %b want 1", K);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 40) == 0) begin
        #2 Reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (K !== 1'b0) begin
          errors++;
          $display("FAIL random_reset_k iter %0d got %b want 0", i, K);
        end
        if ($urandom_range(0, 1) == 0) step(1'($urandom_range(0, 1)));
        Reset = 1'b0;
      end
      step(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
      checks++;
      if (K !== exp_k()) begin
        errors++;
        $display("FAIL random_k iter %0d got %b want %b", i, K, exp_k());
      end
`ifdef COUNTER_STATUS_EN
      checks++;
      if (Count !== CNT_W'(exp_cnt()) || Busy !== exp_busy()) begin
        errors++;
        $display("FAIL random_status iter %0d count %0d busy %b want %0d %b",
                 i, Count, Busy, exp_cnt(), exp_busy());
      end
`endif
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    test_reset();
    test_countdown();
    test_done_hold();
    test_reload_done();
    test_restart_run();
    test_load_held();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
